// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first, aligns on a
// frame sync and hands each word out through a one-deep valid/ready holding buffer.
module shift_deserializer #(
    parameter int unsigned WIDTH        = 8,
    parameter bit          REQUIRE_SYNC = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         direction_i,
    input  logic                         in_i,
    input  logic                         sync_i,
    input  logic                         out_ready_i,
    input  logic                         err_clr_i,
    output logic [WIDTH-1:0]             parallel_out_o,
    output logic                         out_valid_o,
    output logic                         overrun_o,
    output logic                         align_err_o,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count_o
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [0:0] {StHunt, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              align_q, align_d;

    logic              take;
    logic              first;
    logic              misalign;
    logic              dir_eff;
    logic [WIDTH-1:0]  sr_shift;
    logic [CntW-1:0]   cnt_inc;
    logic              complete;
    logic              load_ok;

    // Decide whether this strobe captures a bit and whether it starts a new word.
    always_comb begin
        take     = 1'b0;
        first    = 1'b0;
        misalign = 1'b0;
        if (en_i) begin
            case (state_q)
                StHunt: begin
                    take  = sync_i;
                    first = sync_i;
                end
                StShift: begin
                    take     = 1'b1;
                    first    = sync_i || (cnt_q == '0);
                    misalign = sync_i && (cnt_q != '0);
                end
                default: begin
                    take = 1'b0;
                end
            endcase
        end
    end

    // The first bit of a word uses the live direction input; later bits use the latched one.
    always_comb begin
        dir_eff  = first ? direction_i : dir_q;
        sr_shift = dir_eff ? {sr_q[WIDTH-2:0], in_i} : {in_i, sr_q[WIDTH-1:1]};
        cnt_inc  = first ? CntOne : cnt_q + CntOne;
        complete = take && (cnt_inc == CntFull);
        load_ok  = !valid_q || out_ready_i;
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        out_d     = out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        align_d   = misalign;

        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        if (err_clr_i) begin
            overrun_d = 1'b0;
        end

        if (take) begin
            state_d = StShift;
            sr_d    = sr_shift;
            dir_d   = dir_eff;
            cnt_d   = complete ? '0 : cnt_inc;
        end

        // A dropped word sets overrun after the clear so set wins.
        if (complete) begin
            if (load_ok) begin
                out_d   = sr_shift;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= REQUIRE_SYNC ? StHunt : StShift;
            sr_q      <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b1;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            align_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            align_q   <= align_d;
        end
    end

    assign parallel_out_o = out_q;
    assign out_valid_o    = valid_q;
    assign overrun_o      = overrun_q;
    assign align_err_o    = align_q;
    assign bit_count_o    = cnt_q;

endmodule
